ripple_count_capture: RTL and testbench

Synchronous capture stage placed directly downstream of the 4-bit ripple counter. It brings the counter's asynchronous, glitch-prone 4-bit output into the system clock domain and accepts a value only once it is stable. It extends the count with a wrap counter to form a monotonic event total and flags a programmable threshold. The ripple counter's output decrements (15, 14, …, 0, 15), so down-count mode is the default.

---
 rtl/ripple_count_capture_pkg.sv | 34 +++
 rtl/ripple_count_capture_if.sv | 37 +++
 rtl/ripple_count_capture_sync_stable_filter.sv | 50 +++++
 rtl/ripple_count_capture.sv | 140 ++++++++++++++
 tb/tb_ripple_count_capture.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ripple_count_capture_pkg.sv
// ---------------------------------------------------------------------------
// ripple_cap_pkg
// Shared types and defaults for the ripple-counter capture stage.
//   cap_state_t    : capture FSM states (ACQ = waiting for first value,
//                    TRACK = following the counter and detecting wraps)
//   STABLE_CYC_DEF : default number of equal synchronized samples
//   WRAP_W_DEF     : default wrap-counter width
//   is_wrap()      : direction-aware wrap detection between two 4-bit values
// ---------------------------------------------------------------------------
package ripple_cap_pkg;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } cap_state_t;

    localparam int STABLE_CYC_DEF = 2;
    localparam int WRAP_W_DEF     = 8;

    // A wrap is any step against the counting direction; magnitude is not
    // considered, so skipped source values cannot fake an unwrap.
    function automatic logic is_wrap(input logic [3:0] new_val,
                                     input logic [3:0] old_val,
                                     input logic       down);
        logic wrap_s;
        if (down) begin
            wrap_s = (new_val > old_val);
        end else begin
            wrap_s = (new_val < old_val);
        end
        return wrap_s;
    endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// ---------------------------------------------------------------------------
// ripple_count_capture_if
// Bus bundle between the capture stage and its surroundings.
//   Cnt_In  : raw ripple-counter value (asynchronous to the system clock)
//   Clr     : synchronous clear of the wrap counter and Ovf
//   Thresh  : compare value for Hit
//   Cnt_Out : last accepted 4-bit value
//   Total   : monotonic event total {wrap count, normalized count}
//   Upd     : one-cycle pulse when Cnt_Out changes
//   Wrap    : one-cycle pulse on a detected wrap
//   Hit     : level, Total >= Thresh
//   Ovf     : sticky wrap-counter saturation flag
// master = environment side, slave = capture stage.
// ---------------------------------------------------------------------------
interface ripple_count_capture_if #(
    parameter int WRAP_W = ripple_cap_pkg::WRAP_W_DEF
);
    logic [3:0]        Cnt_In;
    logic              Clr;
    logic [WRAP_W+3:0] Thresh;
    logic [3:0]        Cnt_Out;
    logic [WRAP_W+3:0] Total;
    logic              Upd;
    logic              Wrap;
    logic              Hit;
    logic              Ovf;

    modport master (
        output Cnt_In, Clr, Thresh,
        input  Cnt_Out, Total, Upd, Wrap, Hit, Ovf
    );

    modport slave (
        input  Cnt_In, Clr, Thresh,
        output Cnt_Out, Total, Upd, Wrap, Hit, Ovf
    );
endinterface

// File: rtl/ripple_count_capture_sync_stable_filter.sv
// ---------------------------------------------------------------------------
// sync_stable_filter
// Two-flop synchronizer followed by a stability counter. The synchronized
// value is reported stable once it has held for STABLE_CYC+1 samples.
//   clk, rst   : system clock, synchronous active-high reset
//   cnt_in     : raw asynchronous 4-bit counter value
//   stable_val : synchronized value (second synchronizer flop)
//   stable     : level, stable_val has been steady long enough
// ---------------------------------------------------------------------------
module sync_stable_filter #(
    parameter int STABLE_CYC = ripple_cap_pkg::STABLE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    output logic [3:0] stable_val,
    output logic       stable
);

    localparam logic [3:0] RUN_LIM = 4'(STABLE_CYC);
    localparam logic [3:0] RUN_ONE = 4'd1;

    logic [3:0] s1_r;
    logic [3:0] s2_r;
    logic [3:0] run_r;

    // Synchronizer flops and run counter; run restarts whenever s2 takes a new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r  <= 4'h0;
            s2_r  <= 4'h0;
            run_r <= 4'h0;
        end else begin
            s1_r <= cnt_in;
            s2_r <= s1_r;
            // s1 != s2 here means s2 changes on this edge
            if (s1_r != s2_r) begin
                run_r <= 4'h0;
            end else if (run_r != RUN_LIM) begin
                run_r <= run_r + RUN_ONE;
            end else begin
                run_r <= run_r;
            end
        end
    end

    assign stable_val = s2_r;
    assign stable     = (run_r == RUN_LIM);

endmodule

// File: rtl/ripple_count_capture.sv
// ---------------------------------------------------------------------------
// ripple_count_capture
// Capture stage behind a 4-bit ripple counter: filters the asynchronous
// count, tracks wraps to build a monotonic total and flags a threshold.
//   CLK, RST : system clock, synchronous active-high reset
//   bus      : ripple_count_capture_if.slave (Cnt_In, Clr, Thresh in;
//              Cnt_Out, Total, Upd, Wrap, Hit, Ovf out)
// Parameters: STABLE_CYC (1..15), WRAP_W, DOWN (1 = source counts down).
// ---------------------------------------------------------------------------
module ripple_count_capture #(
    parameter int STABLE_CYC = ripple_cap_pkg::STABLE_CYC_DEF,
    parameter int WRAP_W     = ripple_cap_pkg::WRAP_W_DEF,
    parameter bit DOWN       = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    ripple_count_capture_if.slave   bus
);
    import ripple_cap_pkg::*;

    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    cap_state_t        state_r;
    logic [3:0]        cnt_out_r;
    logic [WRAP_W-1:0] wrap_cnt_r;
    logic              upd_r;
    logic              wrap_r;
    logic              hit_r;
    logic              ovf_r;

    logic [3:0]        stable_val_s;
    logic              stable_s;
    logic              accept_s;
    logic              wrap_evt_s;
    logic [WRAP_W+3:0] total_s;

    sync_stable_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk        (CLK),
        .rst        (RST),
        .cnt_in     (bus.Cnt_In),
        .stable_val (stable_val_s),
        .stable     (stable_s)
    );

    // Acceptance, wrap detection and total, all from registered state.
    always_comb begin
        accept_s   = 1'b0;
        wrap_evt_s = 1'b0;
        total_s    = {(WRAP_W+4){1'b0}};
        if (stable_s) begin
            if (state_r == ACQ) begin
                accept_s = 1'b1;
            end else if (stable_val_s != cnt_out_r) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
        // the very first acquisition has no prior value to wrap from
        if (accept_s && (state_r == TRACK)) begin
            wrap_evt_s = is_wrap(stable_val_s, cnt_out_r, DOWN);
        end else begin
            wrap_evt_s = 1'b0;
        end
        // Total is held at zero until a value has been acquired, so a
        // down-counting source does not report 0xF straight out of reset.
        if (state_r == ACQ) begin
            total_s = {(WRAP_W+4){1'b0}};
        end else if (DOWN) begin
            total_s = {wrap_cnt_r, ~cnt_out_r};
        end else begin
            total_s = {wrap_cnt_r, cnt_out_r};
        end
    end

    // Capture FSM with registered pulses, wrap counter, sticky overflow and Hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ACQ;
            cnt_out_r  <= 4'h0;
            wrap_cnt_r <= {WRAP_W{1'b0}};
            upd_r      <= 1'b0;
            wrap_r     <= 1'b0;
            hit_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            upd_r  <= 1'b0;
            wrap_r <= wrap_evt_s;
            hit_r  <= (total_s >= bus.Thresh);
            case (state_r)
                ACQ: begin
                    if (accept_s) begin
                        cnt_out_r <= stable_val_s;
                        upd_r     <= 1'b1;
                        state_r   <= TRACK;
                    end else begin
                        state_r   <= ACQ;
                    end
                end
                TRACK: begin
                    if (accept_s) begin
                        cnt_out_r <= stable_val_s;
                        upd_r     <= 1'b1;
                    end else begin
                        cnt_out_r <= cnt_out_r;
                    end
                end
                default: begin
                    state_r <= ACQ;
                end
            endcase
            // Clr overrides a coincident wrap; the Wrap pulse above still fires.
            if (bus.Clr) begin
                wrap_cnt_r <= {WRAP_W{1'b0}};
                ovf_r      <= 1'b0;
            end else if (wrap_evt_s) begin
                if (wrap_cnt_r == WRAP_MAX) begin
                    ovf_r <= 1'b1;
                end else begin
                    wrap_cnt_r <= wrap_cnt_r + WRAP_ONE;
                end
            end else begin
                wrap_cnt_r <= wrap_cnt_r;
            end
        end
    end

    assign bus.Cnt_Out = cnt_out_r;
    assign bus.Total   = total_s;
    assign bus.Upd     = upd_r;
    assign bus.Wrap    = wrap_r;
    assign bus.Hit     = hit_r;
    assign bus.Ovf     = ovf_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// ---------------------------------------------------------------------------
// tb_ripple_count_capture
// Directed bench for ripple_count_capture at default parameters
// (STABLE_CYC=2, WRAP_W=8, DOWN=1). Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ripple_count_capture;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   upd_seen;

    ripple_count_capture_if #(.WRAP_W(8)) bus ();

    ripple_count_capture #(
        .STABLE_CYC (2),
        .WRAP_W     (8),
        .DOWN       (1'b1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Present v and check the full acceptance timeline: nothing by edge 3,
    // Upd/Cnt_Out/Wrap/Total at edge 4, one-cycle pulses and Hit at edge 5.
    task automatic accept(input logic [3:0] v, input logic exp_wrap,
                          input logic [11:0] exp_total, input logic exp_hit4,
                          input logic exp_hit5, input string tag);
        bus.Cnt_In = v;
        repeat (4) step();
        chk1({tag, ".upd_e3"}, bus.Upd, 1'b0);
        step();
        chk1({tag, ".upd_e4"}, bus.Upd, 1'b1);
        chk12({tag, ".cnt_e4"}, {8'h00, bus.Cnt_Out}, {8'h00, v});
        chk1({tag, ".wrap_e4"}, bus.Wrap, exp_wrap);
        chk12({tag, ".total_e4"}, bus.Total, exp_total);
        chk1({tag, ".hit_e4"}, bus.Hit, exp_hit4);
        step();
        chk1({tag, ".upd_e5"}, bus.Upd, 1'b0);
        chk1({tag, ".wrap_e5"}, bus.Wrap, 1'b0);
        chk1({tag, ".hit_e5"}, bus.Hit, exp_hit5);
        repeat (2) step();
    endtask

    // Present v long enough to be accepted, without per-cycle checks.
    task automatic apply(input logic [3:0] v);
        bus.Cnt_In = v;
        repeat (6) step();
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.Cnt_In = 4'hA;
        bus.Clr    = 1'b0;
        bus.Thresh = 12'h013;

        // Reset held three cycles
        repeat (3) step();
        chk12("rst.cnt_out", {8'h00, bus.Cnt_Out}, 12'h000);
        chk12("rst.total", bus.Total, 12'h000);
        chk1("rst.upd", bus.Upd, 1'b0);
        chk1("rst.wrap", bus.Wrap, 1'b0);
        chk1("rst.hit", bus.Hit, 1'b0);
        chk1("rst.ovf", bus.Ovf, 1'b0);
        rst = 1'b0;
        accept(4'hA, 1'b0, 12'h005, 1'b0, 1'b0, "acq");

        // Down-count through a wrap, then threshold crossing
        accept(4'h2, 1'b0, 12'h00D, 1'b0, 1'b0, "dn2");
        accept(4'h1, 1'b0, 12'h00E, 1'b0, 1'b0, "dn1");
        accept(4'h0, 1'b0, 12'h00F, 1'b0, 1'b0, "dn0");
        accept(4'hF, 1'b1, 12'h010, 1'b0, 1'b0, "dn15");
        accept(4'hE, 1'b0, 12'h011, 1'b0, 1'b0, "dn14");
        accept(4'hD, 1'b0, 12'h012, 1'b0, 1'b0, "dn13");
        accept(4'hC, 1'b0, 12'h013, 1'b0, 1'b1, "thr");
        accept(4'hB, 1'b0, 12'h014, 1'b1, 1'b1, "thr_hold");

        // Glitch rejection
        accept(4'h8, 1'b0, 12'h017, 1'b1, 1'b1, "steady8");
        upd_seen   = 0;
        bus.Cnt_In = 4'h0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.Upd) upd_seen++;
        end
        bus.Cnt_In = 4'h8;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.Upd) upd_seen++;
        end
        chk12("glitch.upd_count", 12'(upd_seen), 12'h000);
        chk12("glitch.cnt_out", {8'h00, bus.Cnt_Out}, 12'h008);
        // minimum-length hold is accepted even though the input moves on
        bus.Cnt_In = 4'h7;
        repeat (3) step();
        bus.Cnt_In = 4'h6;
        step();
        chk1("hold3.upd_e3", bus.Upd, 1'b0);
        step();
        chk1("hold3.upd_e4", bus.Upd, 1'b1);
        chk12("hold3.cnt_out", {8'h00, bus.Cnt_Out}, 12'h007);
        chk12("hold3.total", bus.Total, 12'h018);
        repeat (8) step();
        chk12("after6.cnt_out", {8'h00, bus.Cnt_Out}, 12'h006);
        chk12("after6.total", bus.Total, 12'h019);

        // Clear with no wrap pending
        bus.Clr = 1'b1;
        step();
        bus.Clr = 1'b0;
        chk12("clr.total", bus.Total, 12'h009);
        chk1("clr.ovf", bus.Ovf, 1'b0);

        // Saturation: 255 wraps fill the counter, the 256th sets Ovf
        for (int i = 0; i < 255; i++) begin
            apply(4'h0);
            apply(4'hF);
        end
        chk12("sat255.total", bus.Total, 12'hFF0);
        chk1("sat255.ovf", bus.Ovf, 1'b0);
        apply(4'h0);
        accept(4'hF, 1'b1, 12'hFF0, 1'b1, 1'b1, "wrap256");
        chk1("wrap256.ovf", bus.Ovf, 1'b1);

        // Clr coincident with a wrap
        apply(4'h0);
        chk12("pre_clrwrap.total", bus.Total, 12'hFFF);
        bus.Cnt_In = 4'hF;
        repeat (4) step();
        bus.Clr = 1'b1;
        step();
        bus.Clr = 1'b0;
        chk1("clrwrap.wrap", bus.Wrap, 1'b1);
        chk1("clrwrap.upd", bus.Upd, 1'b1);
        chk12("clrwrap.total", bus.Total, 12'h000);
        chk1("clrwrap.ovf", bus.Ovf, 1'b0);
        step();
        chk1("clrwrap.hit", bus.Hit, 1'b0);
        chk1("clrwrap.wrap_e5", bus.Wrap, 1'b0);
        repeat (2) step();

        // Build wrap count 5, then reset in the middle of an acceptance
        for (int i = 0; i < 5; i++) begin
            apply(4'h0);
            apply(4'hF);
        end
        chk12("five.total", bus.Total, 12'h050);
        bus.Cnt_In = 4'h3;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk12("midrst.cnt_out", {8'h00, bus.Cnt_Out}, 12'h000);
        chk12("midrst.total", bus.Total, 12'h000);
        chk1("midrst.upd", bus.Upd, 1'b0);
        chk1("midrst.wrap", bus.Wrap, 1'b0);
        chk1("midrst.hit", bus.Hit, 1'b0);
        chk1("midrst.ovf", bus.Ovf, 1'b0);
        rst = 1'b0;
        accept(4'h3, 1'b0, 12'h00C, 1'b0, 1'b0, "reacq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
